// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and beat types for the adder datapath.
package adder_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int IDX_W  = $clog2(MANT_W + 1);

    typedef struct packed {
        logic              carry;
        logic [MANT_W-1:0] mant;
        logic [2:0]        grs;
    } raw_sum_t;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              ovf;
        logic              unf;
    } norm_res_t;
endpackage

// File: rtl/find_first_one.sv
// FindFirstOne: index of the most significant set bit of vec; found = 0 when vec is all zero.
module FindFirstOne #(
    parameter int W = 25
) (
    input  logic [W-1:0]         vec,
    output logic [$clog2(W)-1:0] idx,
    output logic                 found
);
    localparam int IW = $clog2(W);

    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++)
            if (vec[i]) idx = IW'(i);
        found = |vec;
    end
endmodule

// File: rtl/norm_round.sv
// norm_round: shifts the raw sum into 1.xxx form, adjusts the exponent and raises zero/unf/ovf.
// ROUND_NEAREST_EN builds round-to-nearest-even; otherwise G/R/S are truncated.
module norm_round #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int IDX_W  = 5
) (
    input  logic [MANT_W+3:0] sum,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [IDX_W-1:0]  idx,
    input  logic              found,
    output logic [MANT_W-1:0] mant,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              ovf,
    output logic              unf
);
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic              carry;
    logic [XW-1:0]     lsh;
    logic [XW-1:0]     exp_ext;
    logic [XW-1:0]     exp_n;
    logic [XW-1:0]     exp_r;
    logic [MANT_W+2:0] w;
    logic [MANT_W-1:0] mant_n;
    logic [MANT_W-1:0] mant_r;
`ifdef ROUND_NEAREST_EN
    logic [MANT_W:0]   rnd;
`endif

    // w = {mant, guard, round, sticky} after alignment; the carry path folds its low bits into sticky.
    always_comb begin
        carry   = sum[MANT_W+3];
        exp_ext = {2'b00, exp_in};
        lsh     = XW'(MANT_W - 1) - XW'(idx);
        w       = carry ? {sum[MANT_W+3:2], |sum[1:0]} : sum[MANT_W+2:0] << lsh;
        mant_n  = MANT_W'(w >> 3);
        exp_n   = carry ? exp_ext + XW'(1) : exp_ext - lsh;
`ifdef ROUND_NEAREST_EN
        rnd     = {1'b0, mant_n} + {{MANT_W{1'b0}}, w[2] & (|w[1:0] | mant_n[0])};
        mant_r  = rnd[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : rnd[MANT_W-1:0];
        exp_r   = exp_n + {{(XW-1){1'b0}}, rnd[MANT_W]};
`else
        mant_r  = mant_n;
        exp_r   = exp_n;
`endif
        zero    = !found;
        unf     = found && !carry && exp_ext <= lsh;
        ovf     = found && !unf && exp_r >= EXP_MAX;
        mant    = (zero || unf || ovf) ? '0 : mant_r;
        exp_out = (zero || unf) ? '0 : ovf ? '1 : exp_r[EXP_W-1:0];
    end
endmodule

// File: rtl/normalize_stage.sv
// normalize_stage: 2-stage post-add normalizer (S1 = sum + leading-one index, S2 = normalized result).
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates G/R/S.
module normalize_stage #(
    parameter int MANT_W = adder_pkg::MANT_W,
    parameter int EXP_W  = adder_pkg::EXP_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W+3:0] in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);
    import adder_pkg::*;

    localparam int IW = $clog2(MANT_W + 1);

    logic              s1_load, s2_load, s1_take, s2_take;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [MANT_W+3:0] s1_sum_q, s1_sum_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic [IW-1:0]     s1_idx_q, s1_idx_d, ffo_idx;
    logic              s1_found_q, s1_found_d, ffo_found;
    logic [MANT_W-1:0] s2_mant_q, s2_mant_d, nr_mant;
    logic [EXP_W-1:0]  s2_exp_q, s2_exp_d, nr_exp;
    logic              s2_zero_q, s2_zero_d, nr_zero;
    logic              s2_ovf_q, s2_ovf_d, nr_ovf;
    logic              s2_unf_q, s2_unf_d, nr_unf;

    FindFirstOne #(.W(MANT_W + 1)) u_ffo (
        .vec   (in_sum[MANT_W+3:3]),
        .idx   (ffo_idx),
        .found (ffo_found)
    );

    norm_round #(.MANT_W(MANT_W), .EXP_W(EXP_W), .IDX_W(IW)) u_norm_round (
        .sum     (s1_sum_q),
        .exp_in  (s1_exp_q),
        .idx     (s1_idx_q),
        .found   (s1_found_q),
        .mant    (nr_mant),
        .exp_out (nr_exp),
        .zero    (nr_zero),
        .ovf     (nr_ovf),
        .unf     (nr_unf)
    );

    // Each stage advances when empty or when the stage after it drains, so a full pipe still streams.
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_load    = !s1_valid_q || s2_load;
        in_ready   = reset_n && s1_load;
        s1_take    = s1_load && in_valid;
        s2_take    = s2_load && s1_valid_q;
        s1_valid_d = s1_load ? in_valid : s1_valid_q;
        s1_sum_d   = s1_take ? in_sum : s1_sum_q;
        s1_exp_d   = s1_take ? in_exp : s1_exp_q;
        s1_idx_d   = s1_take ? ffo_idx : s1_idx_q;
        s1_found_d = s1_take ? ffo_found : s1_found_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_mant_d  = s2_take ? nr_mant : s2_mant_q;
        s2_exp_d   = s2_take ? nr_exp : s2_exp_q;
        s2_zero_d  = s2_take ? nr_zero : s2_zero_q;
        s2_ovf_d   = s2_take ? nr_ovf : s2_ovf_q;
        s2_unf_d   = s2_take ? nr_unf : s2_unf_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_exp_q   <= '0;
            s1_idx_q   <= '0;
            s1_found_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_exp_q   <= s1_exp_d;
            s1_idx_q   <= s1_idx_d;
            s1_found_q <= s1_found_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_exp_q   <= s2_exp_d;
            s2_zero_q  <= s2_zero_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_unf_q   <= s2_unf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_exp   = s2_exp_q;
    assign out_zero  = s2_zero_q;
    assign out_ovf   = s2_ovf_q;
    assign out_unf   = s2_unf_q;
endmodule

// File: tb/tb_normalize_stage.sv
// tb_normalize_stage: directed and randomized checks of normalize_stage against a behavioural model.
module tb_normalize_stage;
    import adder_pkg::*;

    localparam int SW = MANT_W + 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [SW-1:0]     in_sum = '0;
    logic [EXP_W-1:0]  in_exp = '0;
    logic              in_ready, out_valid, out_zero, out_ovf, out_unf;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    normalize_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // Reference: place the leading one of the sum at the hidden-bit position, scale the exponent by the same distance.
    function automatic norm_res_t model(input logic [SW-1:0] s, input logic [EXP_W-1:0] e);
        norm_res_t r;
        longint v, mant, ex;
        int m, k;
`ifdef ROUND_NEAREST_EN
        longint rem, half;
`endif
        r = '0;
        v = longint'(s);
        m = -1;
        for (int i = 3; i < SW; i++) if (s[i]) m = i;
        if (m < 0) begin
            r.zero = 1'b1;
            return r;
        end
        k = m - (MANT_W - 1);
        mant = k >= 0 ? (v >> k) : (v << (-k));
        mant = mant % (longint'(1) << MANT_W);
        ex = longint'(e) + m - (MANT_W + 2);
`ifdef ROUND_NEAREST_EN
        if (k > 0) begin
            rem  = v % (longint'(1) << k);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && mant % 2 == 1)) mant++;
            if (mant == (longint'(1) << MANT_W)) begin
                mant = longint'(1) << (MANT_W - 1);
                ex++;
            end
        end
`endif
        if (ex <= 0) r.unf = 1'b1;
        else if (ex >= (longint'(1) << EXP_W) - 1) begin
            r.ovf = 1'b1;
            r.exp = '1;
        end else begin
            r.mant = MANT_W'(mant);
            r.exp  = EXP_W'(ex);
        end
        return r;
    endfunction

    function automatic norm_res_t obs();
        return {out_mant, out_exp, out_zero, out_ovf, out_unf};
    endfunction

    function automatic logic [SW-1:0] rand_sum();
        logic [SW-1:0] r;
        r = SW'({$urandom, $urandom});
        return r >> $urandom_range(SW - 1, 0);
    endfunction

    task automatic step(input logic iv, input logic rdy, input logic [SW-1:0] s,
                        input logic [EXP_W-1:0] e, output logic acc, output logic emit);
        @(negedge clock);
        in_valid  = iv;
        out_ready = rdy;
        in_sum    = s;
        in_exp    = e;
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
    endtask

    task automatic run_one(input logic [SW-1:0] s, input logic [EXP_W-1:0] e,
                           output norm_res_t got, output int lat);
        logic acc, emit;
        lat = -1;
        got = '0;
        acc = 1'b0;
        for (int n = 0; n < 8 && !acc; n++) step(1'b1, 1'b1, s, e, acc, emit);
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            step(1'b0, 1'b1, '0, '0, acc, emit);
            if (emit) begin
                lat = n;
                got = obs();
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        tests++;
        if ({in_ready, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_handshake: in_ready,out_valid=%b required 00", {in_ready, out_valid});
        end
        tests++;
        if (obs() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", obs());
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [SW-1:0]    ds[13];
        logic [EXP_W-1:0] de[13];
        norm_res_t        dw[13];
        raw_sum_t         grs_case;
        norm_res_t        got;
        int               lat;
        grs_case = '{carry: 1'b0, mant: 24'hABCDEF, grs: 3'b101};
        ds = '{28'h8000000, 28'h0800000, 28'h0000000, 28'h0200000, 28'h8000000, 28'h0200000, 28'h0200000,
               28'h8000000, grs_case, 28'h1000005, 28'hFFFFFFF, 28'h0000007, 28'h4000000};
        de = '{8'h80, 8'h80, 8'h55, 8'h04, 8'hFE, 8'h06, 8'h05, 8'hFD, 8'h10, 8'h80, 8'h10, 8'h33, 8'hFF};
        dw = '{{24'h800000, 8'h81, 3'b000}, {24'h800000, 8'h7D, 3'b000}, {24'h000000, 8'h00, 3'b100},
               {24'h000000, 8'h00, 3'b001}, {24'h000000, 8'hFF, 3'b010}, {24'h800000, 8'h01, 3'b000},
               {24'h000000, 8'h00, 3'b001}, {24'h800000, 8'hFE, 3'b000}, {24'hABCDEF, 8'h10, 3'b000},
               {24'h800002, 8'h7E, 3'b000}, {24'hFFFFFF, 8'h11, 3'b000}, {24'h000000, 8'h00, 3'b100},
               {24'h000000, 8'hFF, 3'b010}};
`ifdef ROUND_NEAREST_EN
        dw[8]  = {24'hABCDF0, 8'h10, 3'b000};
        dw[10] = {24'h800000, 8'h12, 3'b000};
`endif
        for (int i = 0; i < 13; i++) begin
            run_one(ds[i], de[i], got, lat);
            tests++;
            if (got !== dw[i]) begin
                fails++;
                $display("FAIL directed[%0d]: got %h required %h", i, got, dw[i]);
            end
            tests++;
            if (lat != 2) begin
                fails++;
                $display("FAIL latency[%0d]: got %0d cycles required 2", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0]    s[8];
        logic [EXP_W-1:0] e[8];
        norm_res_t        q[$];
        logic             acc, emit;
        int sent = 0, got = 0, first = -1, last = -1, sent8 = 0;
        for (int i = 0; i < 8; i++) begin
            s[i] = rand_sum();
            e[i] = EXP_W'($urandom);
        end
        for (int n = 0; n < 20 && got < 8; n++) begin
            step(sent < 8, 1'b1, s[sent % 8], e[sent % 8], acc, emit);
            if (emit) begin
                tests++;
                if (q.size() == 0 || obs() !== q[0]) begin
                    fails++;
                    $display("FAIL b2b_beat[%0d]: got %h required %h", got, obs(), q.size() ? q[0] : '0);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
                if (first < 0) first = n;
                last = n;
            end
            if (acc) begin
                q.push_back(model(s[sent % 8], e[sent % 8]));
                sent++;
            end
            if (n == 7) sent8 = sent;
        end
        tests++;
        if (sent8 != 8 || got != 8 || last - first != 7) begin
            fails++;
            $display("FAIL b2b_rate: accepted %0d in 8 cycles, %0d beats over %0d cycles; required 8, 8 over 8",
                     sent8, got, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0]    s[4];
        logic [EXP_W-1:0] e[4];
        norm_res_t        q[$];
        logic             acc, emit;
        int sent = 0, got = 0;
        for (int i = 0; i < 4; i++) begin
            s[i] = rand_sum();
            e[i] = EXP_W'($urandom);
        end
        for (int n = 0; n < 6; n++) begin
            step(sent < 4, 1'b0, s[sent % 4], e[sent % 4], acc, emit);
            if (acc) begin
                q.push_back(model(s[sent % 4], e[sent % 4]));
                sent++;
            end
        end
        tests++;
        if (sent != 2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: accepted %0d in_ready=%b required 2 and 0", sent, in_ready);
        end
        tests++;
        if (out_valid !== 1'b1 || q.size() == 0 || obs() !== q[0]) begin
            fails++;
            $display("FAIL bp_hold: out_valid=%b data %h required 1 and %h", out_valid, obs(), q.size() ? q[0] : '0);
        end
        for (int n = 0; n < 20 && got < 4; n++) begin
            step(sent < 4, 1'b1, s[sent % 4], e[sent % 4], acc, emit);
            if (emit) begin
                tests++;
                if (q.size() == 0 || obs() !== q[0]) begin
                    fails++;
                    $display("FAIL bp_order[%0d]: got %h required %h", got, obs(), q.size() ? q[0] : '0);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(model(s[sent % 4], e[sent % 4]));
                sent++;
            end
        end
        tests++;
        if (got != 4 || sent != 4 || q.size() != 0) begin
            fails++;
            $display("FAIL bp_drain: sent %0d emitted %0d pending %0d required 4, 4, 0", sent, got, q.size());
        end
    endtask

    task automatic test_reset_flush();
        logic      acc, emit;
        int        sent = 0, stale = 0, lat;
        norm_res_t got;
        logic [SW-1:0]    s;
        logic [EXP_W-1:0] e;
        for (int n = 0; n < 4 && sent < 2; n++) begin
            step(1'b1, 1'b0, rand_sum(), EXP_W'($urandom), acc, emit);
            if (acc) sent++;
        end
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        #1;
        tests++;
        if (sent != 2 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid: sent %0d out_valid=%b in_ready=%b required 2, 0, 0", sent, out_valid, in_ready);
        end
        tests++;
        if (obs() !== '0) begin
            fails++;
            $display("FAIL flush_outputs: got %h required 0", obs());
        end
        reset_n = 1'b1;
        s = 28'h0400000;
        e = 8'h40;
        run_one(s, e, got, lat);
        tests++;
        if (got !== model(s, e) || lat != 2) begin
            fails++;
            $display("FAIL flush_restart: got %h in %0d cycles required %h in 2", got, lat, model(s, e));
        end
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 1'b1, '0, '0, acc, emit);
            if (emit) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL flush_stale: %0d extra beats required 0", stale);
        end
    endtask

    task automatic test_random();
        norm_res_t        q[$];
        norm_res_t        prev;
        logic             held, acc, emit, iv, rdy;
        logic [SW-1:0]    s;
        logic [EXP_W-1:0] e;
        held = 1'b0;
        prev = '0;
        s = rand_sum();
        e = EXP_W'($urandom);
        for (int n = 0; n < 400; n++) begin
            iv  = $urandom_range(3, 0) != 0;
            rdy = $urandom_range(3, 0) != 0;
            step(iv, rdy, s, e, acc, emit);
            if (held) begin
                tests++;
                if (out_valid !== 1'b1 || obs() !== prev) begin
                    fails++;
                    $display("FAIL random_hold: out_valid=%b data %h required 1 and %h", out_valid, obs(), prev);
                end
            end
            held = out_valid && !out_ready;
            prev = obs();
            if (emit) begin
                tests++;
                if (q.size() == 0 || obs() !== q[0]) begin
                    fails++;
                    $display("FAIL random_beat: got %h required %h", obs(), q.size() ? q[0] : '0);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(model(s, e));
                s = rand_sum();
                e = EXP_W'($urandom);
            end
        end
        for (int n = 0; n < 10 && q.size() != 0; n++) begin
            step(1'b0, 1'b1, '0, '0, acc, emit);
            if (emit) begin
                tests++;
                if (obs() !== q[0]) begin
                    fails++;
                    $display("FAIL random_drain_beat: got %h required %h", obs(), q[0]);
                end
                void'(q.pop_front());
            end
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL random_drain: %0d beats missing required 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
